// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO register unit.
// Holds the pending-tracker state encoding and default widths.
package hilo_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int PEND_W         = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/hilo_pend_ctr.sv
// Purpose: tracks in-flight mult/div operations and raises a sticky protocol error.
// Latency: count/state/err update on the edge after op_start/res_valid.
// Backpressure: none; an op_start at the limit or a result with nothing pending is dropped.
module hilo_pend_ctr
    import hilo_pkg::*;
#(
    parameter int MAX_PENDING = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    input  logic              res_valid,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              resAccept,
    output logic              busy,
    output logic              err
);

    localparam logic [PEND_W-1:0] MAX_CNT = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] ONE     = PEND_W'(1);

    state_t            state;
    state_t            stateNext;
    logic [PEND_W-1:0] cntNext;
    logic              opAccept;
    logic              atMax;
    logic              errNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pend_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= stateNext;
            pend_cnt <= cntNext;
            err      <= errNext;
        end
    end

    always_comb begin
        resAccept = 1'b0;
        opAccept  = 1'b0;
        atMax     = 1'b0;
        cntNext   = pend_cnt;
        errNext   = err;
        stateNext = state;

        atMax     = (pend_cnt == MAX_CNT);
        resAccept = res_valid && (pend_cnt != '0);
        // A full tracker still takes a new op when a result retires in the same cycle.
        opAccept  = op_start && (!atMax || resAccept);

        case ({opAccept, resAccept})
            2'b10:   cntNext = pend_cnt + ONE;
            2'b01:   cntNext = pend_cnt - ONE;
            default: cntNext = pend_cnt;
        endcase

        if ((op_start && atMax && !res_valid) || (res_valid && pend_cnt == '0))
            errNext = 1'b1;

        case (state)
            IDLE:    if (cntNext != '0) stateNext = BUSY;
            BUSY:    if (cntNext == '0) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/hilo_unit.sv
// Purpose: HI/LO register pair fed by mult/div results and move-to writes; optional
// multiply-accumulate on results when HILO_MACC_EN is defined.
// Latency: writes land 1 cycle after issue; reads are combinational with result forwarding.
// Backpressure: rd_stall holds a HI/LO read while a result it depends on is outstanding.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int MAX_PENDING = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_start,
    input  logic                res_valid,
    input  logic [2*DATA_W-1:0] res_data,
`ifdef HILO_MACC_EN
    input  logic                res_acc,
    input  logic                res_sub,
`endif
    input  logic                mthi,
    input  logic                mtlo,
    input  logic [DATA_W-1:0]   mt_data,
    input  logic                mfhi,
    input  logic                mflo,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_stall,
    output logic                busy,
    output logic [PEND_W-1:0]   pend_cnt,
    output logic                err
);

    logic [DATA_W-1:0]   hiReg;
    logic [DATA_W-1:0]   loReg;
    logic [2*DATA_W-1:0] resVal;
    logic                resAccept;
    logic                fwd;

    hilo_pend_ctr #(
        .MAX_PENDING (MAX_PENDING)
    ) u_pend (
        .clk       (clk),
        .reset     (reset),
        .op_start  (op_start),
        .res_valid (res_valid),
        .pend_cnt  (pend_cnt),
        .resAccept (resAccept),
        .busy      (busy),
        .err       (err)
    );

    // Value a result will leave in {HI,LO}; also the forwarded read source.
`ifdef HILO_MACC_EN
    always_comb begin
        resVal = res_data;
        if (res_acc) begin
            if (res_sub)
                resVal = {hiReg, loReg} - res_data;
            else
                resVal = {hiReg, loReg} + res_data;
        end
    end
`else
    assign resVal = res_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hiReg <= '0;
            loReg <= '0;
        end else begin
            if (mthi)
                hiReg <= mt_data;
            else if (resAccept)
                hiReg <= resVal[2*DATA_W-1:DATA_W];

            if (mtlo)
                loReg <= mt_data;
            else if (resAccept)
                loReg <= resVal[DATA_W-1:0];
        end
    end

    // The last outstanding result arriving now can satisfy a read without stalling.
    assign fwd = (pend_cnt == PEND_W'(1)) && res_valid && !op_start;

    always_comb begin
        rd_data = '0;
        if (mfhi)
            rd_data = fwd ? resVal[2*DATA_W-1:DATA_W] : hiReg;
        else if (mflo)
            rd_data = fwd ? resVal[DATA_W-1:0] : loReg;
    end

    assign rd_stall = (mfhi || mflo) && (pend_cnt != '0) && !fwd;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed checks of hilo_unit: one table row per clock cycle, plus reset and accumulate sequences.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_start;
    logic        res_valid;
    logic [63:0] res_data;
    logic        mthi;
    logic        mtlo;
    logic [31:0] mt_data;
    logic        mfhi;
    logic        mflo;
    logic [31:0] rd_data;
    logic        rd_stall;
    logic        busy;
    logic [2:0]  pend_cnt;
    logic        err;
`ifdef HILO_MACC_EN
    logic        res_acc;
    logic        res_sub;
`endif

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    hilo_unit #(
        .DATA_W      (32),
        .MAX_PENDING (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op_start  (op_start),
        .res_valid (res_valid),
        .res_data  (res_data),
`ifdef HILO_MACC_EN
        .res_acc   (res_acc),
        .res_sub   (res_sub),
`endif
        .mthi      (mthi),
        .mtlo      (mtlo),
        .mt_data   (mt_data),
        .mfhi      (mfhi),
        .mflo      (mflo),
        .rd_data   (rd_data),
        .rd_stall  (rd_stall),
        .busy      (busy),
        .pend_cnt  (pend_cnt),
        .err       (err)
    );

    typedef struct {
        logic        opStart;
        logic        resValid;
        logic [63:0] resData;
        logic        mthi;
        logic        mtlo;
        logic [31:0] mtData;
        logic        mfhi;
        logic        mflo;
        logic [31:0] expRd;
        logic        expStall;
        logic        expBusy;
        logic [2:0]  expPend;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic os, logic rv, logic [63:0] rd, logic mh, logic ml,
                                logic [31:0] md, logic fh, logic fl, logic [31:0] eRd,
                                logic eSt, logic eBz, logic [2:0] ePc, logic eEr);
        vec_t v;
        v.opStart = os;  v.resValid = rv; v.resData = rd;
        v.mthi = mh;     v.mtlo = ml;     v.mtData = md;
        v.mfhi = fh;     v.mflo = fl;
        v.expRd = eRd;   v.expStall = eSt; v.expBusy = eBz;
        v.expPend = ePc; v.expErr = eEr;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        totalCnt++;
        if (act === exp)
            passCnt++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic clearInputs();
        op_start = 0; res_valid = 0; res_data = '0;
        mthi = 0; mtlo = 0; mt_data = '0; mfhi = 0; mflo = 0;
`ifdef HILO_MACC_EN
        res_acc = 0; res_sub = 0;
`endif
    endtask

    task automatic checkAll(string tag, logic [31:0] eRd, logic eSt, logic eBz,
                            logic [2:0] ePc, logic eEr);
        check({tag, " rd_data"},  64'(rd_data),  64'(eRd));
        check({tag, " rd_stall"}, 64'(rd_stall), 64'(eSt));
        check({tag, " busy"},     64'(busy),     64'(eBz));
        check({tag, " pend_cnt"}, 64'(pend_cnt), 64'(ePc));
        check({tag, " err"},      64'(err),      64'(eEr));
    endtask

    task automatic pulseReset();
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        // Watchdog so the bench always terminates.
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        clearInputs();
        reset = 1;
        mfhi  = 1;
        @(negedge clk);
        checkAll("reset", 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        @(posedge clk); #1;
        reset = 0;
        mfhi  = 0;

        //         os rv res_data                mh ml mt_data       fh fl  expRd        st bz pc er
        vecs.push_back(mk(0,0,64'h0,                 1,0,32'hDEADBEEF, 0,0, 32'h0,        0,0,0,0));
        vecs.push_back(mk(0,0,64'h0,                 0,0,32'h0,        1,0, 32'hDEADBEEF, 0,0,0,0));
        vecs.push_back(mk(1,0,64'h0,                 0,0,32'h0,        0,0, 32'h0,        0,0,0,0));
        vecs.push_back(mk(0,0,64'h0,                 0,0,32'h0,        0,1, 32'h0,        1,1,1,0));
        vecs.push_back(mk(0,0,64'h0,                 0,0,32'h0,        0,1, 32'h0,        1,1,1,0));
        vecs.push_back(mk(0,0,64'h0,                 0,0,32'h0,        0,1, 32'h0,        1,1,1,0));
        vecs.push_back(mk(0,1,64'h00000001_00000002, 0,0,32'h0,        0,1, 32'h2,        0,1,1,0));
        vecs.push_back(mk(0,0,64'h0,                 0,0,32'h0,        1,0, 32'h1,        0,0,0,0));
        vecs.push_back(mk(0,0,64'h0,                 0,0,32'h0,        1,1, 32'h1,        0,0,0,0));
        vecs.push_back(mk(1,0,64'h0,                 0,0,32'h0,        0,0, 32'h0,        0,0,0,0));
        vecs.push_back(mk(0,1,64'h11111111_22222222, 0,1,32'h33333333, 0,0, 32'h0,        0,1,1,0));
        vecs.push_back(mk(0,0,64'h0,                 0,0,32'h0,        1,0, 32'h11111111, 0,0,0,0));
        vecs.push_back(mk(0,0,64'h0,                 0,0,32'h0,        0,1, 32'h33333333, 0,0,0,0));
        vecs.push_back(mk(0,0,64'h0,                 1,0,32'hAAAAAAAA, 1,0, 32'h11111111, 0,0,0,0));
        vecs.push_back(mk(0,0,64'h0,                 0,0,32'h0,        1,0, 32'hAAAAAAAA, 0,0,0,0));
        vecs.push_back(mk(1,0,64'h0,                 0,0,32'h0,        0,0, 32'h0,        0,0,0,0));
        vecs.push_back(mk(1,0,64'h0,                 0,0,32'h0,        1,0, 32'hAAAAAAAA, 1,1,1,0));
        vecs.push_back(mk(1,1,64'h00000000_00000007, 0,0,32'h0,        0,0, 32'h0,        0,1,2,0));
        vecs.push_back(mk(0,1,64'h00000002_00000003, 0,0,32'h0,        0,1, 32'h7,        1,1,2,0));
        vecs.push_back(mk(1,1,64'h00000004_00000005, 0,0,32'h0,        1,0, 32'h2,        1,1,1,0));
        vecs.push_back(mk(0,1,64'h00000006_00000007, 0,0,32'h0,        1,0, 32'h6,        0,1,1,0));
        vecs.push_back(mk(0,1,64'h00000008_00000009, 0,0,32'h0,        0,0, 32'h0,        0,0,0,0));
        vecs.push_back(mk(0,0,64'h0,                 0,0,32'h0,        1,1, 32'h6,        0,0,0,1));
        vecs.push_back(mk(0,0,64'h0,                 0,0,32'h0,        0,1, 32'h7,        0,0,0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) begin
                @(posedge clk); #1;
            end
            op_start  = vecs[i].opStart;
            res_valid = vecs[i].resValid;
            res_data  = vecs[i].resData;
            mthi      = vecs[i].mthi;
            mtlo      = vecs[i].mtlo;
            mt_data   = vecs[i].mtData;
            mfhi      = vecs[i].mfhi;
            mflo      = vecs[i].mflo;
            @(negedge clk);
            checkAll($sformatf("row%0d", i), vecs[i].expRd, vecs[i].expStall,
                     vecs[i].expBusy, vecs[i].expPend, vecs[i].expErr);
        end
        @(posedge clk); #1;
        clearInputs();

        // Overflow past MAX_PENDING, then reset while operations are in flight.
        pulseReset();
        op_start = 1;
        repeat (3) @(posedge clk);
        #1 op_start = 0;
        @(negedge clk);
        check("ovf pend_cnt", 64'(pend_cnt), 64'd2);
        check("ovf err",      64'(err),      64'd1);
        check("ovf busy",     64'(busy),     64'd1);
        #2 reset = 1;
        mfhi = 1;
        #1;
        checkAll("midreset", 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        @(posedge clk); #1;
        reset = 0;
        mfhi = 0;
        res_valid = 1;
        res_data  = 64'hCAFEF00D_12345678;
        @(posedge clk); #1;
        res_valid = 0;
        mfhi = 1;
        @(negedge clk);
        checkAll("postreset res", 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        mfhi = 0;
        mflo = 1;
        #1;
        check("postreset lo", 64'(rd_data), 64'h0);
        clearInputs();

`ifdef HILO_MACC_EN
        pulseReset();
        mthi = 1; mtlo = 1; mt_data = 32'h0;
        @(posedge clk); #1;
        mthi = 0; mt_data = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mtlo = 0; op_start = 1;
        @(posedge clk); #1;
        op_start = 0;
        res_valid = 1; res_data = 64'h1; res_acc = 1; res_sub = 0;
        mfhi = 1;
        @(negedge clk);
        check("macc fwd hi",    64'(rd_data),  64'h1);
        check("macc fwd stall", 64'(rd_stall), 64'h0);
        @(posedge clk); #1;
        clearInputs();
        mfhi = 1;
        @(negedge clk);
        check("macc add hi", 64'(rd_data), 64'h1);
        mfhi = 0; mflo = 1;
        #1;
        check("macc add lo", 64'(rd_data), 64'h0);
        @(posedge clk); #1;
        clearInputs();
        op_start = 1;
        @(posedge clk); #1;
        op_start = 0;
        res_valid = 1; res_data = 64'h1; res_acc = 1; res_sub = 1;
        @(posedge clk); #1;
        clearInputs();
        mfhi = 1;
        @(negedge clk);
        check("macc sub hi", 64'(rd_data), 64'h0);
        mfhi = 0; mflo = 1;
        #1;
        check("macc sub lo", 64'(rd_data), 64'hFFFFFFFF);
        clearInputs();
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
